axis_ifmap_loader: RTL

Parametrised AXI-Stream ingest engine for the conv/pool accelerator. It decodes the host LOADIFMAPS instruction and the shape fields from the AXI control registers. It accepts ifmap row words from the stream and scatters them round-robin across BANK_NUM ifmap BRAM banks, one bank per kernel row, with per-bank address generation. It sits between the AXIS slave port and the ifmap BRAMs in top and reports busy/done/error status back to the control register file.

---
 rtl/axis_ifmap_pkg.sv | 45 ++++
 rtl/ifmap_bank_addr_gen.sv | 55 +++++
 rtl/axis_ifmap_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/axis_ifmap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_ifmap_pkg
// Description : Shared opcodes, loader state encoding and kernel one-hot decode.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_ifmap_pkg;

    localparam logic [7:0] INST_COMPUTE    = 8'd87;
    localparam logic [7:0] INST_LOADIFMAPS = 8'd88;
    localparam logic [7:0] INST_ABORT      = 8'hFF;

    // Widest kernel one-hot the decoder handles; BANK_NUM must not exceed it.
    localparam int ONEHOT_MAX = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] index;
    } onehot_dec_t;

    function automatic onehot_dec_t onehot_to_index(input logic [ONEHOT_MAX-1:0] onehot);
        onehot_dec_t res;
        int unsigned hits;
        res  = '0;
        hits = 0;
        for (int i = 0; i < ONEHOT_MAX; i++) begin
            if (onehot[i]) begin
                res.index = 4'(i);
                hits++;
            end
        end
        res.valid = (hits == 1);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifmap_bank_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : ifmap_bank_addr_gen
// Description : Round-robin bank counter wrapping at K-1 with per-wrap address
//               increment and a sticky address-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ifmap_bank_addr_gen #(
    parameter int BANK_NUM           = 5,
    parameter int BRAM_ADDRESS_WIDTH = 12,
    parameter int BW                 = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          advance,
    input  logic [BW-1:0]                 k_last,
    output logic [BW-1:0]                 bank,
    output logic [BRAM_ADDRESS_WIDTH-1:0] addr,
    output logic                          overflow
);

    logic [BW-1:0]                 r_bank;
    logic [BRAM_ADDRESS_WIDTH-1:0] r_addr;
    logic                          r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank <= '0;
            r_addr <= '0;
            r_ovf  <= 1'b0;
        end else if (clear) begin
            r_bank <= '0;
            r_addr <= '0;
            r_ovf  <= 1'b0;
        end else if (advance) begin
            if (r_bank == k_last) begin
                r_bank <= '0;
                r_addr <= r_addr + 1'b1;
                // Wrapping past the top row means the next word has nowhere to go.
                if (&r_addr) begin
                    r_ovf <= 1'b1;
                end
            end else begin
                r_bank <= r_bank + 1'b1;
            end
        end
    end

    assign bank     = r_bank;
    assign addr     = r_addr;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: rtl/axis_ifmap_loader.sv
`default_nettype none
// ============================================================================
// Module      : axis_ifmap_loader
// Description : AXI-Stream ifmap ingest; scatters row words round-robin over
//               K ifmap BRAM banks and reports busy/done/error status.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_ifmap_loader
    import axis_ifmap_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_ADDRESS_WIDTH   = 12,
    parameter int BANK_NUM             = 5,
    parameter int CNT_WIDTH            = 24
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    input  logic [7:0]                      ctrl_inst,
    input  logic [11:0]                     ctrl_in_channel,
    input  logic [BANK_NUM-1:0]             ctrl_kernel_onehot,
    input  logic [11:0]                     ctrl_row_count,
    output logic [BANK_NUM-1:0]             bram_we,
    output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_addr,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] bram_wdata,
    output logic                            load_busy,
    output logic                            load_done,
    output logic                            load_err,
    output logic [CNT_WIDTH-1:0]            words_loaded
);

    localparam int BW    = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int CAP_W = CNT_WIDTH + BRAM_ADDRESS_WIDTH + 2;

    state_t                          r_state, w_state_next;
    logic                            r_armed, r_done, r_err;
    logic [BW-1:0]                   r_k_last;
    logic [CNT_WIDTH-1:0]            r_n_last, r_words;
    logic [BANK_NUM-1:0]             r_we;
    logic [BRAM_ADDRESS_WIDTH-1:0]   r_addr;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] r_wdata;

    onehot_dec_t                   w_dec;
    logic [23:0]                   w_prod;
    logic [CNT_WIDTH-1:0]          w_n;
    logic [CAP_W-1:0]              w_cap;
    logic                          w_cfg_ok, w_accept, w_final, w_write, w_enter_check, w_ovf;
    logic [BW-1:0]                 w_bank;
    logic [BRAM_ADDRESS_WIDTH-1:0] w_addr;

    assign w_dec  = onehot_to_index(ONEHOT_MAX'(ctrl_kernel_onehot));
    assign w_prod = {12'd0, ctrl_in_channel} * {12'd0, ctrl_row_count};
    assign w_n    = CNT_WIDTH'(w_prod);
    // ceil(N/K) > 2^AW is equivalent to N > K * 2^AW.
    assign w_cap  = (CAP_W'(w_dec.index) + CAP_W'(1)) << BRAM_ADDRESS_WIDTH;
    assign w_cfg_ok = w_dec.valid && (ctrl_in_channel != '0) && (ctrl_row_count != '0)
                   && (CAP_W'(w_n) <= w_cap);

    assign w_accept      = (r_state == ST_LOAD) && s_axis_tvalid;
    assign w_final       = w_accept && (r_words == r_n_last);
    assign w_write       = w_accept && !w_ovf;
    assign w_enter_check = (r_state == ST_IDLE) && (w_state_next == ST_CHECK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (ctrl_inst == INST_LOADIFMAPS && r_armed) w_state_next = ST_CHECK;
            ST_CHECK: w_state_next = w_cfg_ok ? ST_LOAD : ST_ERR;
            ST_LOAD: begin
                if (ctrl_inst == INST_ABORT)  w_state_next = ST_IDLE;
                else if (w_accept && w_ovf)   w_state_next = ST_ERR;
                else if (w_final)             w_state_next = ST_DONE;
                else if (w_accept && s_axis_tlast) w_state_next = ST_ERR;
            end
            ST_DONE, ST_ERR: if (ctrl_inst != INST_LOADIFMAPS) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_k_last <= '0;
            r_n_last <= '0;
            r_words  <= '0;
            r_we     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            if (w_enter_check) begin
                r_armed <= 1'b0;
            end else if (ctrl_inst != INST_LOADIFMAPS) begin
                r_armed <= 1'b1;
            end

            if (r_state == ST_CHECK) begin
                r_k_last <= BW'(w_dec.index);
                r_n_last <= w_n - CNT_WIDTH'(1);
            end

            if (w_enter_check) begin
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_words <= '0;
            end else begin
                if (w_state_next == ST_DONE && r_state != ST_DONE) r_done <= 1'b1;
                if (w_state_next == ST_ERR && r_state != ST_ERR)   r_err  <= 1'b1;
                if (w_accept && !(&r_words))                       r_words <= r_words + 1'b1;
            end

            r_we <= '0;
            if (w_write) begin
                r_we    <= BANK_NUM'(1) << w_bank;
                r_addr  <= w_addr;
                r_wdata <= s_axis_tdata;
            end
        end
    end

    ifmap_bank_addr_gen #(
        .BANK_NUM           (BANK_NUM),
        .BRAM_ADDRESS_WIDTH (BRAM_ADDRESS_WIDTH),
        .BW                 (BW)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_enter_check),
        .advance  (w_accept),
        .k_last   (r_k_last),
        .bank     (w_bank),
        .addr     (w_addr),
        .overflow (w_ovf)
    );

    assign s_axis_tready = (r_state == ST_LOAD);
    assign load_busy     = (r_state == ST_LOAD);
    assign load_done     = r_done;
    assign load_err      = r_err;
    assign words_loaded  = r_words;
    assign bram_we       = r_we;
    assign bram_addr     = r_addr;
    assign bram_wdata    = r_wdata;

endmodule
`default_nettype wire
